// File: rtl/mem_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Line refills and write-throughs use a one-word-per-ack request/acknowledge handshake to main memory.
module mem_stage_dcache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        hit,
  output logic [31:0] readData,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} cacheState_e;

  cacheState_e state, stateNext;

  logic [31:0]      dataArr [LINES][WORDS];
  logic [TAG_W-1:0] tagArr  [LINES];
  logic [LINES-1:0] valid;

  logic [TAG_W-1:0] reqTag, latchTag;
  logic [IDX_W-1:0] reqIdx, latchIdx;
  logic [OFF_W-1:0] reqOff, latchOff;
  logic [OFF_W-1:0] counter, nextCount;
  logic             lookupHit;
  logic             unusedByteOff;

  assign reqTag        = address[31 -: TAG_W];
  assign reqIdx        = address[2 + OFF_W +: IDX_W];
  assign reqOff        = address[2 +: OFF_W];
  assign unusedByteOff = ^address[1:0];
  assign nextCount     = counter + 1'b1;
  assign lookupHit     = valid[reqIdx] && (tagArr[reqIdx] == reqTag);
  assign stall         = (memRead | memWrite) & ~hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // A store always wins over a load; hits are reported combinationally in IDLE.
  always_comb begin
    stateNext = state;
    hit       = 1'b0;
    readData  = 32'h0;
    case (state)
      IDLE: begin
        if (memWrite) begin
          stateNext = WRITE;
        end else if (memRead) begin
          if (lookupHit) begin
            hit      = 1'b1;
            readData = dataArr[reqIdx][reqOff];
          end else begin
            stateNext = REFILL;
          end
        end
      end
      REFILL: if (memAck && counter == LAST_WORD) stateNext = IDLE;
      WRITE: begin
        if (memAck) begin
          hit       = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered memory-side handshake, latched request fields and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      counter  <= '0;
      latchTag <= '0;
      latchIdx <= '0;
      latchOff <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= 32'h0;
      memWdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (memWrite) begin
            latchTag <= reqTag;
            latchIdx <= reqIdx;
            latchOff <= reqOff;
            memReq   <= 1'b1;
            memWe    <= 1'b1;
            memAddr  <= {address[31:2], 2'b00};
            memWdata <= writeData;
          end else if (memRead && !lookupHit) begin
            valid[reqIdx] <= 1'b0;
            latchTag      <= reqTag;
            latchIdx      <= reqIdx;
            counter       <= '0;
            memReq        <= 1'b1;
            memWe         <= 1'b0;
            memAddr       <= {reqTag, reqIdx, {OFF_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (memAck) begin
            counter <= nextCount;
            if (counter == LAST_WORD) begin
              valid[latchIdx] <= 1'b1;
              memReq          <= 1'b0;
            end else begin
              memAddr <= {latchTag, latchIdx, nextCount, 2'b00};
            end
          end
        end
        WRITE: begin
          if (memAck) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone decide residency.
  always_ff @(posedge clk) begin
    if (state == REFILL && memAck) begin
      dataArr[latchIdx][counter] <= memRdata;
      if (counter == LAST_WORD) tagArr[latchIdx] <= latchTag;
    end else if (state == WRITE && memAck && valid[latchIdx] &&
                 tagArr[latchIdx] == latchTag) begin
      dataArr[latchIdx][latchOff] <= memWdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: a vector table for single-cycle lookups and
// hand-written sequences for refills, stores, conflicts and reset during a refill.
module tb_mem_stage_dcache;

  logic        clk = 1'b0;
  logic        rst_n, memRead, memWrite, hit, stall, memReq, memWe, memAck;
  logic [31:0] address, writeData, readData, memAddr, memWdata, memRdata;

  int compared = 0, mismatched = 0;
  int ackDelay = 2, ackBudget = -1, waitCnt = 0, memTxn = 0;
  logic [31:0] mainMem [logic [31:0]];
  logic [31:0] ackAddrQ [$];
  logic        lastAckWe;
  logic [31:0] lastAckWdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic        expHit;
    logic [31:0] expData;
    logic        expStall;
  } vecT;
  vecT vecs [7];

  mem_stage_dcache #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .address(address), .writeData(writeData), .hit(hit), .readData(readData),
    .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (mainMem.exists(a)) return mainMem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Main-memory model: acks ackDelay cycles after each request, at most ackBudget acks when >= 0.
  initial begin
    memAck   = 1'b0;
    memRdata = 32'h0;
    forever begin
      @(negedge clk);
      if (memAck) begin
        memAck  = 1'b0;
        waitCnt = 0;
      end
      if (memReq && ackBudget != 0) begin
        waitCnt++;
        if (waitCnt >= ackDelay) begin
          memAck  = 1'b1;
          waitCnt = 0;
          memTxn++;
          if (ackBudget > 0) ackBudget--;
          if (memWe) mainMem[memAddr] = memWdata;
          else       memRdata = memWord(memAddr);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    memRead   = rd;
    memWrite  = wr;
    address   = addr;
    writeData = wd;
  endtask

  // Holds one request until hit (bounded), recording acked addresses and stall cycles.
  task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           output int stallCycles, output logic [31:0] data, output int txn,
                           output logic hitMemReq, output logic done);
    int startTxn;
    startTxn    = memTxn;
    stallCycles = 0;
    data        = 32'h0;
    hitMemReq   = 1'b1;
    done        = 1'b0;
    ackAddrQ.delete();
    applyStimulus(rd, wr, addr, wd);
    for (int c = 0; c < 60; c++) begin
      #2;
      if (memAck) begin
        ackAddrQ.push_back(memAddr);
        lastAckWe    = memWe;
        lastAckWdata = memWdata;
      end
      if (hit) begin
        data      = readData;
        hitMemReq = memReq;
        done      = 1'b1;
        break;
      end
      if (stall) stallCycles++;
      @(negedge clk);
    end
    txn = memTxn - startTxn;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkLoad(input string name, input logic [31:0] addr, input logic [31:0] expData,
                           input int expTxn, input int expStall);
    int sc, txn;
    logic [31:0] d;
    logic mr, ok;
    runAccess(1'b1, 1'b0, addr, 32'h0, sc, d, txn, mr, ok);
    checkOutput({name, " done"}, 32'(ok), 32'd1);
    checkOutput({name, " data"}, d, expData);
    checkOutput({name, " memTxn"}, txn, expTxn);
    checkOutput({name, " stallCycles"}, sc, expStall);
    checkOutput({name, " memReqOnHit"}, 32'(mr), 32'd0);
  endtask

  task automatic checkRefillAddrs(input string name, input logic [31:0] base);
    logic [31:0] got;
    checkOutput({name, " ackCount"}, ackAddrQ.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < ackAddrQ.size()) ? ackAddrQ[i] : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s addr%0d", name, i), got, base + 32'(4 * i));
    end
  endtask

  task automatic checkStore(input string name, input logic [31:0] addr, input logic [31:0] wd);
    int sc, txn;
    logic [31:0] d;
    logic mr, ok;
    runAccess(1'b0, 1'b1, addr, wd, sc, d, txn, mr, ok);
    checkOutput({name, " done"}, 32'(ok), 32'd1);
    checkOutput({name, " memTxn"}, txn, 32'd1);
    checkOutput({name, " stallCycles"}, sc, 32'd2);
    checkOutput({name, " ackAddr"}, (ackAddrQ.size() > 0) ? ackAddrQ[0] : 32'hFFFF_FFFF, addr);
    checkOutput({name, " ackWe"}, 32'(lastAckWe), 32'd1);
    checkOutput({name, " ackWdata"}, lastAckWdata, wd);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h100, 1'b1, 32'hA0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h108, 1'b1, 32'hA2, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h10C, 1'b1, 32'hA3, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h104, 1'b1, 32'hA1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h10B, 1'b1, 32'hA2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0,  1'b0};
    vecs[6] = '{1'b0, 1'b0, 32'h3F0, 1'b0, 32'h0,  1'b0};
    for (int i = 0; i < 4; i++) mainMem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

    memRead = 1'b0; memWrite = 1'b0; address = 32'h0; writeData = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset hit", 32'(hit), 32'd0);
    checkOutput("reset readData", readData, 32'h0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset memReq", 32'(memReq), 32'd0);
    checkOutput("reset memWe", 32'(memWe), 32'd0);
    checkOutput("reset memAddr", memAddr, 32'h0);
    checkOutput("reset memWdata", memWdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] cold load 0x100");
    checkLoad("coldLoad", 32'h100, 32'hA0, 4, 9);
    checkRefillAddrs("coldLoad", 32'h100);

    $display("[TB] lookup vector table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, 32'h0);
      #2;
      checkOutput($sformatf("vec%0d hit", i), 32'(hit), 32'(vecs[i].expHit));
      checkOutput($sformatf("vec%0d readData", i), readData, vecs[i].expData);
      checkOutput($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].expStall));
      checkOutput($sformatf("vec%0d memReq", i), 32'(memReq), 32'd0);
    end

    $display("[TB] store to resident line");
    checkStore("storeHit", 32'h104, 32'hDEAD_BEEF);
    checkOutput("storeHit mainMem", memWord(32'h104), 32'hDEAD_BEEF);
    checkLoad("loadAfterStore", 32'h104, 32'hDEAD_BEEF, 0, 0);

    $display("[TB] store to non-resident line");
    checkStore("storeMiss", 32'h2000, 32'h1122_3344);
    checkLoad("noAllocate", 32'h100, 32'hA0, 0, 0);
    checkLoad("loadAfterStoreMiss", 32'h2000, 32'h1122_3344, 4, 9);
    checkRefillAddrs("loadAfterStoreMiss", 32'h2000);

    $display("[TB] conflict misses with back-to-back acks");
    ackDelay = 1;
    checkLoad("conflictA", 32'h100, 32'hA0, 4, 5);
    checkLoad("conflictB", 32'h1100, 32'h5A5A_1100, 4, 5);
    checkRefillAddrs("conflictB", 32'h1100);
    checkLoad("conflictA2", 32'h100, 32'hA0, 4, 5);
    checkLoad("writeThroughKept", 32'h104, 32'hDEAD_BEEF, 0, 0);

    $display("[TB] reset during refill");
    ackBudget = 2;
    applyStimulus(1'b1, 1'b0, 32'h340, 32'h0);
    #2;
    checkOutput("abort missStall", 32'(stall), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("abort midReq", 32'(memReq), 32'd1);
    checkOutput("abort midAddr", memAddr, 32'h348);
    rst_n = 1'b0;
    #1;
    checkOutput("abort memReq", 32'(memReq), 32'd0);
    checkOutput("abort memAddr", memAddr, 32'h0);
    checkOutput("abort hit", 32'(hit), 32'd0);
    checkOutput("abort stall", 32'(stall), 32'd1);
    memRead = 1'b0;
    #1;
    checkOutput("abort idleStall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    ackBudget = -1;
    ackDelay  = 2;
    checkLoad("afterAbort", 32'h340, 32'h5A5A_0340, 4, 9);
    checkRefillAddrs("afterAbort", 32'h340);
    checkLoad("afterAbortHit", 32'h34C, 32'h5A5A_034C, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
